// File: rtl/ucsbece154a_membridge.sv
// Memory-side bridge: registers a datapath access and holds a req/ack handshake to a variable-latency memory.
// Define UCSBECE154A_MEMBRIDGE_TIMEOUT_EN to abort requests unacknowledged after TIMEOUT cycles (sticky err_o).
module ucsbece154a_membridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              we_i,
  input  logic              re_i,
  output logic [DATA_W-1:0] rd_o,
  output logic              stall_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rd_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("ucsbece154a_membridge: TIMEOUT must be within 2..255");
  end

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
  logic [DATA_W-1:0] rd_q, rd_d;

`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    mem_adr_d = mem_adr_q;
    mem_wd_d  = mem_wd_q;
    rd_d      = rd_q;
`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (we_i || re_i) begin
          mem_adr_d = adr_i;
          mem_wd_d  = wd_i;
          mem_we_d  = we_i;
          mem_req_d = 1'b1;
          state_d   = REQ;
`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
          cnt_d     = 8'd0;
`endif
        end
      end
      REQ: begin
        // An ack always wins over the timeout threshold in the same cycle.
        if (mem_ack_i) begin
          if (!mem_we_q) rd_d = mem_rd_i;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end
`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          if (!mem_we_q) rd_d = DATA_W'(32'hDEADBEEF);
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_adr_q <= '0;
      mem_wd_q  <= '0;
      rd_q      <= '0;
`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      mem_adr_q <= mem_adr_d;
      mem_wd_q  <= mem_wd_d;
      rd_q      <= rd_d;
`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  // Stall in IDLE follows the request combinationally so the requester holds that same cycle.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      IDLE:    stall_o = we_i | re_i;
      REQ:     stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  assign rd_o      = rd_q;
  assign mem_req_o = mem_req_q;
  assign mem_we_o  = mem_we_q;
  assign mem_adr_o = mem_adr_q;
  assign mem_wd_o  = mem_wd_q;

`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ucsbece154a_membridge.sv
// Scoreboard bench for ucsbece154a_membridge: driver pushes hand-computed expectations, monitor checks each completed access.
module tb_ucsbece154a_membridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] adr_i = '0;
  logic [31:0] wd_i = '0;
  logic        we_i = 1'b0;
  logic        re_i = 1'b0;
  logic [31:0] rd_o;
  logic        stall_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_wd_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rd_i = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        we;
    logic        err;
    int          reqCycles;
    int          stallCycles;
  } exp_t;

  exp_t sbQ[$];
  bit   monEn = 1'b0;
  bit   prevReq = 1'b0;
  int   reqCnt = 0;
  int   stallCnt = 0;

  ucsbece154a_membridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .adr_i(adr_i), .wd_i(wd_i), .we_i(we_i), .re_i(re_i),
    .rd_o(rd_o), .stall_o(stall_o), .err_o(err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o), .mem_wd_o(mem_wd_o),
    .mem_ack_i(mem_ack_i), .mem_rd_i(mem_rd_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: an access completes when mem_req_o falls; compare against the oldest expectation.
  always @(negedge clk) begin
    if (!monEn) begin
      reqCnt = 0;
      stallCnt = 0;
    end else begin
      if (mem_req_o) reqCnt++;
      if (stall_o) stallCnt++;
      if (prevReq && !mem_req_o) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("mem_adr_o", mem_adr_o, e.adr);
          checkOutput("mem_we_o", {31'd0, mem_we_o}, {31'd0, e.we});
          if (e.we) checkOutput("mem_wd_o", mem_wd_o, e.wd);
          checkOutput("rd_o", rd_o, e.rd);
          checkOutput("err_o", {31'd0, err_o}, {31'd0, e.err});
          checkOutput("req cycles", reqCnt, e.reqCycles);
          checkOutput("stall cycles", stallCnt, e.stallCycles);
          checkOutput("stall in DONE", {31'd0, stall_o}, 32'd0);
        end
        reqCnt = 0;
        stallCnt = 0;
      end
    end
    prevReq = mem_req_o;
  end

  // ackDelay 0 means no ack at all (timeout build only); hold keeps we/re high through DONE.
  task automatic applyStimulus(input logic we, input logic re, input logic [31:0] adr,
                               input logic [31:0] wd, input logic [31:0] rdata,
                               input int ackDelay, input bit hold,
                               input logic [31:0] expRd, input logic expErr,
                               input int expReq, input int expStall);
    exp_t e;
    e.adr = adr; e.wd = wd; e.rd = expRd; e.we = we; e.err = expErr;
    e.reqCycles = expReq; e.stallCycles = expStall;
    sbQ.push_back(e);
    @(posedge clk); #1;
    we_i = we; re_i = re; adr_i = adr; wd_i = wd;
    @(posedge clk); #1;
    if (!hold) begin
      we_i = 1'b0; re_i = 1'b0;
      adr_i = 32'hFFFF_FFF0; wd_i = 32'h0BAD_0BAD;
    end
    if (ackDelay > 0) begin
      repeat (ackDelay - 1) @(posedge clk);
      #1 mem_ack_i = 1'b1; mem_rd_i = rdata;
      @(posedge clk); #1;
      mem_ack_i = 1'b0; mem_rd_i = 32'h0;
    end else begin
      repeat (16) @(posedge clk);
      #1;
    end
    if (hold) begin
      @(negedge clk);
      checkOutput("held stall in DONE", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      we_i = 1'b0; re_i = 1'b0;
      @(negedge clk);
      checkOutput("no reissue req", {31'd0, mem_req_o}, 32'd0);
      @(posedge clk); #1;
      checkOutput("no reissue req later", {31'd0, mem_req_o}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset mem_req_o", {31'd0, mem_req_o}, 32'd0);
    checkOutput("reset mem_we_o", {31'd0, mem_we_o}, 32'd0);
    checkOutput("reset mem_adr_o", mem_adr_o, 32'd0);
    checkOutput("reset mem_wd_o", mem_wd_o, 32'd0);
    checkOutput("reset rd_o", rd_o, 32'd0);
    checkOutput("reset err_o", {31'd0, err_o}, 32'd0);
    checkOutput("reset stall_o", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    monEn = 1'b1;

    applyStimulus(1'b0, 1'b1, 32'h10, 32'h0, 32'h00500093, 3, 1'b0, 32'h00500093, 1'b0, 3, 4);
    applyStimulus(1'b1, 1'b0, 32'h60, 32'hCAFEF00D, 32'h77777777, 1, 1'b0, 32'h00500093, 1'b0, 1, 2);
    applyStimulus(1'b1, 1'b1, 32'h80, 32'h11112222, 32'h99999999, 2, 1'b1, 32'h00500093, 1'b0, 2, 3);

    @(posedge clk); #1 mem_ack_i = 1'b1; mem_rd_i = 32'h12345678;
    @(posedge clk); #1 mem_ack_i = 1'b0; mem_rd_i = 32'h0;
    @(negedge clk);
    checkOutput("spurious ack rd_o", rd_o, 32'h00500093);
    checkOutput("spurious ack mem_req_o", {31'd0, mem_req_o}, 32'd0);
    checkOutput("spurious ack stall_o", {31'd0, stall_o}, 32'd0);

    applyStimulus(1'b0, 1'b1, 32'h24, 32'h0, 32'hA5A5A5A5, 1, 1'b0, 32'hA5A5A5A5, 1'b0, 1, 2);
    applyStimulus(1'b0, 1'b1, 32'h28, 32'h0, 32'h0F0F0F0F, 2, 1'b0, 32'h0F0F0F0F, 1'b0, 2, 3);

    @(posedge clk); #1;
    monEn = 1'b0;
    re_i = 1'b1; adr_i = 32'h44;
    @(posedge clk); #1 re_i = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("mid-REQ reset mem_req_o", {31'd0, mem_req_o}, 32'd0);
    checkOutput("mid-REQ reset rd_o", rd_o, 32'd0);
    checkOutput("mid-REQ reset stall_o", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1 mem_ack_i = 1'b1; mem_rd_i = 32'hFFFF0000;
    @(posedge clk); #1 mem_ack_i = 1'b0; mem_rd_i = 32'h0;
    @(negedge clk);
    checkOutput("late ack rd_o", rd_o, 32'd0);
    checkOutput("late ack mem_req_o", {31'd0, mem_req_o}, 32'd0);
    checkOutput("late ack stall_o", {31'd0, stall_o}, 32'd0);
    monEn = 1'b1;

`ifdef UCSBECE154A_MEMBRIDGE_TIMEOUT_EN
    applyStimulus(1'b0, 1'b1, 32'h30, 32'h0, 32'h13579BDF, 16, 1'b0, 32'h13579BDF, 1'b0, 16, 17);
    applyStimulus(1'b0, 1'b1, 32'h34, 32'h0, 32'h0, 0, 1'b0, 32'hDEADBEEF, 1'b1, 16, 17);
    applyStimulus(1'b1, 1'b0, 32'h38, 32'h55AA55AA, 32'h0, 1, 1'b0, 32'hDEADBEEF, 1'b1, 1, 2);
`else
    applyStimulus(1'b0, 1'b1, 32'h30, 32'h0, 32'h13579BDF, 16, 1'b0, 32'h13579BDF, 1'b0, 16, 17);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
